instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end stage that sits directly upstream of the DataPath's instruction register. It holds the SPARC V8 PC/nPC pair, issues word reads to instruction RAM with the MFC completion handshake, and drives `IR_In`/`IR_Enable` into the DataPath. It applies delayed-branch redirection and annulment, and flags misaligned or timed-out fetches to the ControlUnit.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; nPC resets to `RESET_PC + 4`.
- `TIMEOUT`, default 15: number of WAIT cycles without MFC before a fetch faults; legal range 1 to 255.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Clr`  in  1  reset, asynchronous, active-low.
- `fetch_req`  in  1  ControlUnit request for the next instruction; sampled only in IDLE.
- `branch_taken`  in  1  redirect strobe, sampled every cycle.
- `branch_target`  in  32  redirect address, captured when `branch_taken`=1.
- `annul`  in  1  annul the next delivered instruction (delay slot), sampled every cycle.
- `fault_ack`  in  1  clears the sticky fault.
- `mem_addr`  out  32  RAM word address.
- `mem_read`  out  1  RAM read request.
- `mem_data_in`  in  32  RAM read data, valid when `MFC`=1.
- `MFC`  in  1  memory function complete.
- `IR_In`  out  32  instruction to the DataPath IR.
- `IR_Enable`  out  1  one-cycle IR load strobe.
- `ready`  out  1  high in IDLE only.
- `PC`, `nPC`  out  32  architectural program counters.
- `fetch_fault`  out  1  sticky fault flag.
- `fault_code`  out  2  00 none, 01 misaligned, 10 timeout.

## Operation
- FSM states are IDLE, WAIT, LOAD. Reset enters IDLE.
- IDLE with `fetch_req`=1:
  - `PC[1:0]`≠0: set `fetch_fault`=1 and `fault_code`=01. No memory access. Stay in IDLE. PC and nPC unchanged.
  - Otherwise: register `mem_addr`=PC and `mem_read`=1, clear the wait counter, and go to WAIT.
- WAIT: `mem_read` stays high and `mem_addr` stays stable.
  - `MFC`=1: register `IR_In` from `mem_data_in`, drop `mem_read`, go to LOAD.
  - `MFC`=0: increment the 8-bit wait counter. If this is the TIMEOUT-th such cycle, drop `mem_read`, set `fetch_fault`=1 and `fault_code`=10, and return to IDLE. PC and nPC are unchanged.
- LOAD: `IR_Enable`=1 for exactly one cycle, then return to IDLE. On the same edge: `PC`←`nPC`; `nPC`←the pending target if a redirect is pending, else `nPC+4` (modulo 2^32). The pending redirect is then cleared.
- Redirect: `branch_taken`=1 in any state sets redirect-pending and captures `branch_target`; a later strobe overwrites the earlier one. The instruction in flight (or the next one fetched) is the delay slot and executes; the target follows it.
- Annul: `annul`=1 sets annul-pending. The next LOAD presents `IR_In`=32'h0100_0000 (NOP) instead of the fetched word, with `IR_Enable` still pulsed and PC advanced normally. Annul-pending then clears.
- `annul` and `branch_taken` asserted in the same cycle: both are latched, giving an annulled delay slot followed by a fetch from the target.
- `fetch_fault` is sticky. While it is set, `fetch_req` is ignored. `fault_ack`=1 clears it and `fault_code` to 00 on the next edge. If a new fault and `fault_ack` occur together, the fault wins.
- Reset is asynchronous and active-low (`Clr`=0). It aborts any fetch immediately and sets: PC=`RESET_PC`, nPC=`RESET_PC+4`, `mem_addr`=0, `mem_read`=0, `IR_In`=0, `IR_Enable`=0, `fetch_fault`=0, `fault_code`=00, `ready`=1, all pending flags 0, wait counter 0.

## Timing
- `fetch_req` sampled at edge N gives `mem_read`=1 during cycle N+1.
- With `MFC`=1 during the first WAIT cycle, `IR_Enable`=1 during cycle N+2 and the updated PC is visible in cycle N+3. Minimum request-to-IR latency is 2 edges.
- Each additional MFC-low WAIT cycle adds one cycle of latency.
- `ready` falls in the cycle after an accepted request and rises in the cycle after LOAD. Back-to-back fetches issue every 3 cycles at best.
- `IR_In` is held stable from the LOAD cycle until the next MFC capture.
- A timeout returns to IDLE on the edge that samples the TIMEOUT-th low MFC.

## Test plan
- Reset, then a single fetch with MFC after 0 waits and RAM[0]=32'h82004002 -> `IR_Enable` pulses in cycle N+2, `IR_In`=32'h82004002, PC=4, nPC=8.
- Sequential 31-instruction stream of arithmetic words with destination 1 to 31 (pattern `{2'b10,rd,25'h0803004}`) -> each word is delivered in order and PC ends at 0x7C.
- `branch_taken` with target 0x100 during the fetch at PC=0x8 -> next fetches are at 0xC (delay slot), then 0x100; nPC=0x104.
- `annul` together with `branch_taken` (target 0x40) at PC=0x10 -> 0x14 delivered as 32'h01000000, next fetch at 0x40.
- MFC held low with TIMEOUT=15 -> after 15 WAIT cycles, `fetch_fault`=1, `fault_code`=10, `mem_read`=0, PC unchanged; `fault_ack` clears both; forcing PC=0x2 via a redirect yields `fault_code`=01 with no `mem_read`.
- `Clr` pulsed low mid-WAIT -> all outputs immediately take their reset values, and the next fetch starts from `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC/nPC pair, runs one word read per
// request against instruction RAM, and hands the word to the DataPath IR.
// Delayed branches, delay-slot annulment and fetch faults are handled here.
//
// Memory handshake: mem_read rises on the edge that accepts a request, with
// mem_addr registered on that same edge. Both then hold steady until an edge
// samples MFC=1 (mem_data_in is taken on that edge) or the fetch times out.
// mem_read drops on that edge. A one-cycle IR_Enable strobe follows a capture.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        fetch_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        annul,
  input  logic        fault_ack,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_data_in,
  input  logic        MFC,
  output logic [31:0] IR_In,
  output logic        IR_Enable,
  output logic        ready,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic        fetch_fault,
  output logic [1:0]  fault_code,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD    = 32'h0100_0000;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [1:0]  CODE_NONE   = 2'b00;
  localparam logic [1:0]  CODE_ALIGN  = 2'b01;
  localparam logic [1:0]  CODE_TMO    = 2'b10;

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_inc;
  logic        redir_pend;
  logic [31:0] redir_target;
  logic        annul_pend;
  logic        accept;
  logic        misaligned;
  logic        timed_out;
  logic        capture;

  // Request decode, timeout detection and next-state selection.
  always_comb begin
    wait_cnt_inc = wait_cnt + 8'd1;
    accept       = (state == S_IDLE) && fetch_req && !fetch_fault && (PC[1:0] == 2'b00);
    misaligned   = (state == S_IDLE) && fetch_req && !fetch_fault && (PC[1:0] != 2'b00);
    capture      = (state == S_WAIT) && MFC;
    timed_out    = (state == S_WAIT) && !MFC && (wait_cnt_inc == TIMEOUT_CNT);
    state_next   = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_WAIT;
      S_WAIT: begin
        if (capture)        state_next = S_LOAD;
        else if (timed_out) state_next = S_IDLE;
      end
      S_LOAD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign IR_Enable = (state == S_LOAD);
  assign ready     = (state == S_IDLE);
  assign fsm_state = state;

  // State register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state <= S_IDLE;
    else      state <= state_next;
  end

  // Memory request, wait counter and IR capture.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mem_addr <= 32'h0;
      mem_read <= 1'b0;
      wait_cnt <= 8'h0;
      IR_In    <= 32'h0;
    end else begin
      if (accept) begin
        mem_addr <= PC;
        mem_read <= 1'b1;
        wait_cnt <= 8'h0;
      end else if (capture) begin
        mem_read <= 1'b0;
        // An annul latched earlier, or raised on this very edge, replaces the word.
        IR_In    <= (annul_pend || annul) ? NOP_WORD : mem_data_in;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt_inc;
        if (timed_out) mem_read <= 1'b0;
      end
    end
  end

  // PC/nPC advance on LOAD; a strobe arriving during LOAD redirects right away.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      PC  <= RESET_PC;
      nPC <= RESET_PC + 32'd4;
    end else if (state == S_LOAD) begin
      PC <= nPC;
      if (branch_taken)    nPC <= branch_target;
      else if (redir_pend) nPC <= redir_target;
      else                 nPC <= nPC + 32'd4;
    end
  end

  // Pending redirect and annul: consumed by LOAD, later strobes overwrite.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      redir_pend   <= 1'b0;
      redir_target <= 32'h0;
      annul_pend   <= 1'b0;
    end else if (state == S_LOAD) begin
      redir_pend <= 1'b0;
      // An annul seen during LOAD targets the following instruction.
      annul_pend <= annul;
    end else begin
      if (branch_taken) begin
        redir_pend   <= 1'b1;
        redir_target <= branch_target;
      end
      if (annul) annul_pend <= 1'b1;
    end
  end

  // Sticky fault flag; a new fault beats a simultaneous acknowledge.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      fetch_fault <= 1'b0;
      fault_code  <= CODE_NONE;
    end else if (misaligned) begin
      fetch_fault <= 1'b1;
      fault_code  <= CODE_ALIGN;
    end else if (timed_out) begin
      fetch_fault <= 1'b1;
      fault_code  <= CODE_TMO;
    end else if (fault_ack) begin
      fetch_fault <= 1'b0;
      fault_code  <= CODE_NONE;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: reset state, in-order stream, delayed
// branch, annulled delay slot, timeout and misaligned faults, async reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP_WORD = 32'h0100_0000;

  logic        Clk, Clr;
  logic        fetch_req, branch_taken, annul, fault_ack, MFC;
  logic [31:0] branch_target, mem_data_in;
  logic [31:0] mem_addr, IR_In, PC, nPC;
  logic        mem_read, IR_Enable, ready, fetch_fault;
  logic [1:0]  fault_code, fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    int          waits;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
  } vec_t;
  vec_t vecs[31];

  instruction_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(15)) dut (
    .Clk(Clk), .Clr(Clr), .fetch_req(fetch_req), .branch_taken(branch_taken),
    .branch_target(branch_target), .annul(annul), .fault_ack(fault_ack),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_data_in(mem_data_in),
    .MFC(MFC), .IR_In(IR_In), .IR_Enable(IR_Enable), .ready(ready),
    .PC(PC), .nPC(nPC), .fetch_fault(fetch_fault), .fault_code(fault_code),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, actual=running required=done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Scoreboard: every IR_Enable pulse must match the next expected word.
  always @(negedge Clk) begin
    if (Clr && IR_Enable) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ir_enable", 32'h1, 32'h0);
      else chk("sb_ir_word", IR_In, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    Clr = 1'b0;
    fetch_req = 0; branch_taken = 0; annul = 0; fault_ack = 0; MFC = 0;
    branch_target = 32'h0; mem_data_in = 32'h0;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
  endtask

  // One complete fetch. phase: 0 no strobe, 1 strobe in first WAIT cycle,
  // 2 strobe in the LOAD cycle.
  task automatic fetch(input string tag, input logic [31:0] word, input int waits,
                       input logic [31:0] exp_addr, input logic [31:0] exp_ir,
                       input logic [31:0] exp_pc, input logic [31:0] exp_npc,
                       input int phase, input logic ann, input logic [31:0] tgt);
    @(negedge Clk);
    chk({tag, ".ready_idle"}, {31'h0, ready}, 32'h1);
    fetch_req = 1'b1;
    @(negedge Clk);
    fetch_req = 1'b0;
    chk({tag, ".mem_read"}, {31'h0, mem_read}, 32'h1);
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    chk({tag, ".ready_busy"}, {31'h0, ready}, 32'h0);
    if (phase == 1) begin branch_taken = 1'b1; branch_target = tgt; annul = ann; end
    for (int i = 0; i < waits; i++) begin
      @(negedge Clk);
      branch_taken = 1'b0; annul = 1'b0;
      chk({tag, ".mem_read_hold"}, {31'h0, mem_read}, 32'h1);
      chk({tag, ".mem_addr_hold"}, mem_addr, exp_addr);
    end
    MFC = 1'b1;
    mem_data_in = word;
    exp_q.push_back(exp_ir);
    @(negedge Clk);
    MFC = 1'b0; branch_taken = 1'b0; annul = 1'b0;
    mem_data_in = $urandom;
    chk({tag, ".ir_enable"}, {31'h0, IR_Enable}, 32'h1);
    chk({tag, ".mem_read_drop"}, {31'h0, mem_read}, 32'h0);
    if (phase == 2) begin branch_taken = 1'b1; branch_target = tgt; annul = ann; end
    @(negedge Clk);
    branch_taken = 1'b0; annul = 1'b0;
    chk({tag, ".ir_enable_low"}, {31'h0, IR_Enable}, 32'h0);
    chk({tag, ".ir_hold"}, IR_In, exp_ir);
    chk({tag, ".pc"}, PC, exp_pc);
    chk({tag, ".npc"}, nPC, exp_npc);
  endtask

  initial begin
    for (int k = 0; k < 31; k++) begin
      vecs[k].word     = {2'b10, 5'(k + 1), 25'h0803004};
      vecs[k].waits    = k % 3;
      vecs[k].exp_addr = 32'(k * 4);
      vecs[k].exp_pc   = 32'((k + 1) * 4);
      vecs[k].exp_npc  = 32'((k + 2) * 4);
    end

    // Reset state, then a single zero-wait fetch.
    do_reset();
    @(negedge Clk);
    chk("rst.pc", PC, 32'h0);
    chk("rst.npc", nPC, 32'h4);
    chk("rst.mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.ir_in", IR_In, 32'h0);
    chk("rst.ir_enable", {31'h0, IR_Enable}, 32'h0);
    chk("rst.ready", {31'h0, ready}, 32'h1);
    chk("rst.fault", {29'h0, fetch_fault, fault_code}, 32'h0);
    chk("rst.state", {30'h0, fsm_state}, 32'h0);
    fetch("single", 32'h82004002, 0, 32'h0, 32'h82004002, 32'h4, 32'h8, 0, 1'b0, 32'h0);

    // 31-word sequential stream with varying MFC latency.
    do_reset();
    for (int k = 0; k < 31; k++)
      fetch($sformatf("seq%0d", k), vecs[k].word, vecs[k].waits, vecs[k].exp_addr,
            vecs[k].word, vecs[k].exp_pc, vecs[k].exp_npc, 0, 1'b0, 32'h0);
    chk("seq.final_pc", PC, 32'h7C);

    // Delayed branch: strobe during the fetch at 0x8.
    do_reset();
    fetch("br0", 32'hA0000001, 0, 32'h0, 32'hA0000001, 32'h4, 32'h8, 0, 1'b0, 32'h0);
    fetch("br1", 32'hA0000002, 1, 32'h4, 32'hA0000002, 32'h8, 32'hC, 0, 1'b0, 32'h0);
    fetch("br2", 32'hA0000003, 2, 32'h8, 32'hA0000003, 32'hC, 32'h100, 1, 1'b0, 32'h100);
    fetch("br_slot", 32'hA0000004, 0, 32'hC, 32'hA0000004, 32'h100, 32'h104, 0, 1'b0, 32'h0);
    fetch("br_tgt", 32'hA0000005, 0, 32'h100, 32'hA0000005, 32'h104, 32'h108, 0, 1'b0, 32'h0);

    // Annul plus branch raised in the LOAD of the branch at 0x10.
    do_reset();
    for (int k = 0; k < 4; k++)
      fetch($sformatf("an%0d", k), vecs[k].word, 0, vecs[k].exp_addr, vecs[k].word,
            vecs[k].exp_pc, vecs[k].exp_npc, 0, 1'b0, 32'h0);
    fetch("an_br", 32'hB0000010, 0, 32'h10, 32'hB0000010, 32'h14, 32'h40, 2, 1'b1, 32'h40);
    fetch("an_slot", 32'hB0000014, 1, 32'h14, NOP_WORD, 32'h40, 32'h44, 0, 1'b0, 32'h0);
    fetch("an_tgt", 32'hB0000040, 0, 32'h40, 32'hB0000040, 32'h44, 32'h48, 0, 1'b0, 32'h0);

    // Timeout with MFC held low.
    do_reset();
    @(negedge Clk);
    fetch_req = 1'b1;
    @(negedge Clk);
    fetch_req = 1'b0;
    repeat (14) @(negedge Clk);
    chk("tmo.read_before", {31'h0, mem_read}, 32'h1);
    chk("tmo.fault_before", {31'h0, fetch_fault}, 32'h0);
    @(negedge Clk);
    chk("tmo.mem_read", {31'h0, mem_read}, 32'h0);
    chk("tmo.fault", {31'h0, fetch_fault}, 32'h1);
    chk("tmo.code", {30'h0, fault_code}, 32'h2);
    chk("tmo.pc", PC, 32'h0);
    chk("tmo.ready", {31'h0, ready}, 32'h1);
    fetch_req = 1'b1;
    @(negedge Clk);
    fetch_req = 1'b0;
    chk("tmo.req_ignored", {31'h0, mem_read}, 32'h0);
    fault_ack = 1'b1;
    @(negedge Clk);
    fault_ack = 1'b0;
    chk("tmo.ack_fault", {31'h0, fetch_fault}, 32'h0);
    chk("tmo.ack_code", {30'h0, fault_code}, 32'h0);

    // Misaligned PC reached through a redirect to 0x2.
    fetch("mis0", 32'hC0000000, 0, 32'h0, 32'hC0000000, 32'h4, 32'h2, 1, 1'b0, 32'h2);
    fetch("mis1", 32'hC0000004, 0, 32'h4, 32'hC0000004, 32'h2, 32'h6, 0, 1'b0, 32'h0);
    @(negedge Clk);
    fetch_req = 1'b1;
    @(negedge Clk);
    fetch_req = 1'b0;
    chk("mis.fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis.code", {30'h0, fault_code}, 32'h1);
    chk("mis.mem_read", {31'h0, mem_read}, 32'h0);
    chk("mis.ready", {31'h0, ready}, 32'h1);
    chk("mis.pc", PC, 32'h2);
    fault_ack = 1'b1;
    @(negedge Clk);
    fault_ack = 1'b0;
    chk("mis.ack", {29'h0, fetch_fault, fault_code}, 32'h0);

    // Asynchronous reset in the middle of a WAIT.
    do_reset();
    fetch("ar0", 32'hD0000000, 0, 32'h0, 32'hD0000000, 32'h4, 32'h8, 0, 1'b0, 32'h0);
    @(negedge Clk);
    fetch_req = 1'b1;
    @(negedge Clk);
    fetch_req = 1'b0;
    chk("ar.in_wait", {31'h0, mem_read}, 32'h1);
    #2 Clr = 1'b0;
    #1;
    chk("ar.mem_read", {31'h0, mem_read}, 32'h0);
    chk("ar.mem_addr", mem_addr, 32'h0);
    chk("ar.pc", PC, 32'h0);
    chk("ar.npc", nPC, 32'h4);
    chk("ar.ir_in", IR_In, 32'h0);
    chk("ar.ready", {31'h0, ready}, 32'h1);
    @(negedge Clk);
    Clr = 1'b1;
    fetch("ar_after", 32'hD0000001, 0, 32'h0, 32'hD0000001, 32'h4, 32'h8, 0, 1'b0, 32'h0);

    repeat (2) @(negedge Clk);
    chk("sb.drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
